des_capture_buffer: RTL and testbench
=====================================

# des_capture_buffer

Trigger-based snapshot buffer for the 288-bit ADC sample word produced by the 72:288 deserializer, clocked on the divided-by-4 data clock. The buffer is armed by software, captures continuously into a circular memory, and freezes a window of pre-trigger and post-trigger words on a trigger. The frozen window is then read back word by word through a registered read port for the scan/debug path.

## Interface
Parameters:
- DEPTH, 64: words stored; must be a power of 2, minimum 4.
- ADDR_W, 6: log2(DEPTH).

Ports:
- clk  in  1  divided-by-4 data clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_0 … in_31  in  9 each  deserialized samples; in_k occupies bits [9k+8:9k] of the stored word.
- in_valid  in  1  the sample word is valid this cycle.
- arm  in  1  single-cycle pulse that starts a new capture.
- trigger  in  1  level; sampled only in ARMED.
- post_count  in  ADDR_W  number of words to capture after the trigger word; latched on the trigger cycle.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  logical index; 0 is the oldest captured word.
- rd_data_0 … rd_data_31  out  9 each  read data, same lane mapping as the inputs.
- rd_valid  out  1  rd_data_* is valid.
- state  out  2  IDLE=00, ARMED=01, POST=10, DONE=11.
- done  out  1  high when state is DONE.
- words_valid  out  ADDR_W+1  number of valid captured words, range 0..DEPTH.
- trig_index  out  ADDR_W+1  logical index of the trigger word; valid in DONE.

## Operation
- IDLE: no writes.
  - An arm pulse clears wr_ptr, the written count and the wrapped flag, then moves to ARMED.
- ARMED: each in_valid cycle writes mem[wr_ptr] and increments wr_ptr modulo DEPTH.
  - The wrapped flag sets when wr_ptr wraps from DEPTH-1 to 0.
  - trigger=1 latches remaining=post_count.
    - If in_valid=1 on the trigger cycle, that word is the trigger word.
    - Otherwise, the next valid word is the trigger word.
  - Go to POST. If post_count=0, go to DONE after the trigger word is written.
- POST: each in_valid write decrements remaining. The write that brings remaining to 0 moves the block to DONE.
- DONE: writes are blocked.
  - rd_base = wr_ptr if the wrapped flag is set, otherwise 0.
  - Physical read address = (rd_base + rd_addr) mod DEPTH.
  - words_valid = DEPTH if wrapped, otherwise wr_ptr. If wr_ptr=0 and the flag is clear, words_valid = 0.
  - trig_index = words_valid − 1 − post_count (uses the latched post_count).
- Reads are honoured only in DONE.
  - rd_en outside DONE gives rd_valid=0, and rd_data holds its last value.
  - rd_addr ≥ words_valid returns the stale memory contents with rd_valid=1. Software is responsible for bounding reads.
- arm in any state, including ARMED, POST and DONE, restarts the capture: go to ARMED with pointers cleared.
- arm and trigger in the same cycle: arm wins, and the trigger is ignored.
- trigger is ignored in IDLE, POST and DONE.
- post_count ≥ DEPTH−1: the whole buffer is post-trigger. trig_index = 0 once the buffer has wrapped.
- rst (mid-capture or at any time):
  - state = IDLE; pointers, flags and remaining cleared.
  - rd_valid = 0 and rd_data_* = 0.
  - words_valid = 0 and trig_index = 0.
  - Memory contents are not cleared.

## Timing
- A write is committed on the rising edge that samples in_valid=1.
- The state output updates on the edge after the deciding input (arm, trigger, final write).
- done rises on the edge that commits the last post-trigger word.
- Read latency is 1 cycle: rd_en sampled at edge N gives rd_data/rd_valid after edge N, for one cycle. Back-to-back reads sustain one word per cycle.
- A write and a read never occur in the same cycle, so no bypass is required.
- words_valid and trig_index are combinational from registered state. They are stable throughout DONE.

## Structure
- Package des_capture_pkg holds:
  - the state encoding localparams ST_IDLE, ST_ARMED, ST_POST, ST_DONE;
  - the lane constants NLANE=32 and LANE_W=9.
- Sub-module des_capture_mem: DEPTH×288 storage with one synchronous write port and one registered read port. This keeps the storage mappable to a macro.
- The top level holds the FSM, pointers, remaining counter, lane packing/unpacking and address offset logic.

## Test plan
- Reset mid-POST, then read with rd_en=1 → state=00, rd_valid=0, words_valid=0; memory still holds the earlier data.
- arm, then 10 valid words, trigger on word 10 with post_count=3, then 3 more words → done after the 14th write. words_valid=14, trig_index=10, and rd_addr 0..13 return the words in write order.
- arm, then 100 words with DEPTH=64, trigger with post_count=5 → words_valid=64, trig_index=58. rd_addr=0 returns word 42 (the oldest after wrap).
- Trigger with post_count=0 and in_valid=1 → DONE on the next edge; trig_index = words_valid−1.
- arm and trigger in the same cycle → state=ARMED (trigger ignored). A later trigger is accepted normally.
- rd_en in ARMED → rd_valid stays 0. in_valid gaps during POST do not decrement remaining.

Source files
------------

// File: rtl/des_capture_pkg.sv
// Shared constants and the state type for the ADC snapshot capture buffer.
package des_capture_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ARMED = 2'b01;
    localparam logic [1:0] ST_POST  = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    localparam int NLANE  = 32;
    localparam int LANE_W = 9;
    localparam int WORD_W = NLANE * LANE_W;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ARMED = ST_ARMED,
        S_POST  = ST_POST,
        S_DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/des_capture_mem.sv
// Capture storage: one synchronous write port, one registered read port.
// Only the read register is reset so the array itself can map onto a RAM macro.
module des_capture_mem
    import des_capture_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int WIDTH  = WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/des_capture_buffer.sv
// Trigger-based snapshot buffer for the 288-bit deserialized ADC word: circular
// pre-trigger capture, post-trigger countdown, then frozen readback in logical order.
module des_capture_buffer
    import des_capture_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [8:0]        in_0,  in_1,  in_2,  in_3,  in_4,  in_5,  in_6,  in_7,
    input  logic [8:0]        in_8,  in_9,  in_10, in_11, in_12, in_13, in_14, in_15,
    input  logic [8:0]        in_16, in_17, in_18, in_19, in_20, in_21, in_22, in_23,
    input  logic [8:0]        in_24, in_25, in_26, in_27, in_28, in_29, in_30, in_31,
    input  logic              in_valid,
    input  logic              arm,
    input  logic              trigger,
    input  logic [ADDR_W-1:0] post_count,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [8:0]        rd_data_0,  rd_data_1,  rd_data_2,  rd_data_3,
    output logic [8:0]        rd_data_4,  rd_data_5,  rd_data_6,  rd_data_7,
    output logic [8:0]        rd_data_8,  rd_data_9,  rd_data_10, rd_data_11,
    output logic [8:0]        rd_data_12, rd_data_13, rd_data_14, rd_data_15,
    output logic [8:0]        rd_data_16, rd_data_17, rd_data_18, rd_data_19,
    output logic [8:0]        rd_data_20, rd_data_21, rd_data_22, rd_data_23,
    output logic [8:0]        rd_data_24, rd_data_25, rd_data_26, rd_data_27,
    output logic [8:0]        rd_data_28, rd_data_29, rd_data_30, rd_data_31,
    output logic              rd_valid,
    output logic [1:0]        state,
    output logic              done,
    output logic [ADDR_W:0]   words_valid,
    output logic [ADDR_W:0]   trig_index
);

    localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   FULL    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              wrapped_q, wrapped_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0] post_q, post_d;
    logic              done_q, done_d;
    logic              rd_valid_q, rd_valid_d;

    logic              wr_en;
    logic              rd_fire;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] rd_phys;
    logic [ADDR_W:0]   words_valid_w;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;

    assign wr_word = {in_31, in_30, in_29, in_28, in_27, in_26, in_25, in_24,
                      in_23, in_22, in_21, in_20, in_19, in_18, in_17, in_16,
                      in_15, in_14, in_13, in_12, in_11, in_10, in_9,  in_8,
                      in_7,  in_6,  in_5,  in_4,  in_3,  in_2,  in_1,  in_0};

    assign {rd_data_31, rd_data_30, rd_data_29, rd_data_28,
            rd_data_27, rd_data_26, rd_data_25, rd_data_24,
            rd_data_23, rd_data_22, rd_data_21, rd_data_20,
            rd_data_19, rd_data_18, rd_data_17, rd_data_16,
            rd_data_15, rd_data_14, rd_data_13, rd_data_12,
            rd_data_11, rd_data_10, rd_data_9,  rd_data_8,
            rd_data_7,  rd_data_6,  rd_data_5,  rd_data_4,
            rd_data_3,  rd_data_2,  rd_data_1,  rd_data_0} = rd_word;

    // An arm pulse restarts the capture, so it also suppresses that cycle's write.
    assign wr_en   = !arm && in_valid && (state_q == S_ARMED || state_q == S_POST);
    assign rd_fire = rd_en && (state_q == S_DONE);

    // Once wrapped, the oldest surviving word sits at the write pointer.
    assign rd_base       = wrapped_q ? wr_ptr_q : '0;
    assign rd_phys       = rd_base + rd_addr;
    assign words_valid_w = wrapped_q ? FULL : {1'b0, wr_ptr_q};

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wrapped_d   = wrapped_q;
        remaining_d = remaining_q;
        post_d      = post_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (&wr_ptr_q) begin
                wrapped_d = 1'b1;
            end
        end

        if (arm) begin
            state_d     = S_ARMED;
            wr_ptr_d    = '0;
            wrapped_d   = 1'b0;
            remaining_d = '0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (trigger) begin
                        post_d = post_count;
                        // Without a word this cycle, the next valid write is the trigger
                        // word, so it is counted as one extra write before DONE.
                        if (in_valid && post_count == '0) begin
                            state_d = S_DONE;
                        end else if (in_valid) begin
                            state_d     = S_POST;
                            remaining_d = {1'b0, post_count};
                        end else begin
                            state_d     = S_POST;
                            remaining_d = {1'b0, post_count} + REM_ONE;
                        end
                    end
                end
                S_POST: begin
                    if (in_valid) begin
                        remaining_d = remaining_q - REM_ONE;
                        if (remaining_q == REM_ONE) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end

        done_d     = (state_d == S_DONE);
        rd_valid_d = rd_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            wrapped_q   <= 1'b0;
            remaining_q <= '0;
            post_q      <= '0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wrapped_q   <= wrapped_d;
            remaining_q <= remaining_d;
            post_q      <= post_d;
            done_q      <= done_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    des_capture_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (WORD_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_word),
        .rd_en   (rd_fire),
        .rd_addr (rd_phys),
        .rd_data (rd_word)
    );

    assign state       = state_q;
    assign done        = done_q;
    assign rd_valid    = rd_valid_q;
    assign words_valid = words_valid_w;
    assign trig_index  = (state_q == S_DONE) ? (words_valid_w - REM_ONE - {1'b0, post_q}) : '0;

endmodule

// File: tb/tb_des_capture_buffer.sv
// Self-checking bench for des_capture_buffer: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the captured word history.
module tb_des_capture_buffer;

    localparam int DEPTH = 64;
    localparam int WW    = 288;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          arm = 1'b0;
    logic          trigger = 1'b0;
    logic          rd_en = 1'b0;
    logic [5:0]    post_count = '0;
    logic [5:0]    rd_addr = '0;
    logic [WW-1:0] in_word = '0;
    wire  [WW-1:0] rd_word;
    wire           rd_valid;
    wire           done;
    wire  [1:0]    state;
    wire  [6:0]    words_valid;
    wire  [6:0]    trig_index;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    des_capture_buffer #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst),
        .in_0(in_word[0 +: 9]),    .in_1(in_word[9 +: 9]),    .in_2(in_word[18 +: 9]),   .in_3(in_word[27 +: 9]),
        .in_4(in_word[36 +: 9]),   .in_5(in_word[45 +: 9]),   .in_6(in_word[54 +: 9]),   .in_7(in_word[63 +: 9]),
        .in_8(in_word[72 +: 9]),   .in_9(in_word[81 +: 9]),   .in_10(in_word[90 +: 9]),  .in_11(in_word[99 +: 9]),
        .in_12(in_word[108 +: 9]), .in_13(in_word[117 +: 9]), .in_14(in_word[126 +: 9]), .in_15(in_word[135 +: 9]),
        .in_16(in_word[144 +: 9]), .in_17(in_word[153 +: 9]), .in_18(in_word[162 +: 9]), .in_19(in_word[171 +: 9]),
        .in_20(in_word[180 +: 9]), .in_21(in_word[189 +: 9]), .in_22(in_word[198 +: 9]), .in_23(in_word[207 +: 9]),
        .in_24(in_word[216 +: 9]), .in_25(in_word[225 +: 9]), .in_26(in_word[234 +: 9]), .in_27(in_word[243 +: 9]),
        .in_28(in_word[252 +: 9]), .in_29(in_word[261 +: 9]), .in_30(in_word[270 +: 9]), .in_31(in_word[279 +: 9]),
        .in_valid(in_valid), .arm(arm), .trigger(trigger), .post_count(post_count),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data_0(rd_word[0 +: 9]),     .rd_data_1(rd_word[9 +: 9]),     .rd_data_2(rd_word[18 +: 9]),
        .rd_data_3(rd_word[27 +: 9]),    .rd_data_4(rd_word[36 +: 9]),    .rd_data_5(rd_word[45 +: 9]),
        .rd_data_6(rd_word[54 +: 9]),    .rd_data_7(rd_word[63 +: 9]),    .rd_data_8(rd_word[72 +: 9]),
        .rd_data_9(rd_word[81 +: 9]),    .rd_data_10(rd_word[90 +: 9]),   .rd_data_11(rd_word[99 +: 9]),
        .rd_data_12(rd_word[108 +: 9]),  .rd_data_13(rd_word[117 +: 9]),  .rd_data_14(rd_word[126 +: 9]),
        .rd_data_15(rd_word[135 +: 9]),  .rd_data_16(rd_word[144 +: 9]),  .rd_data_17(rd_word[153 +: 9]),
        .rd_data_18(rd_word[162 +: 9]),  .rd_data_19(rd_word[171 +: 9]),  .rd_data_20(rd_word[180 +: 9]),
        .rd_data_21(rd_word[189 +: 9]),  .rd_data_22(rd_word[198 +: 9]),  .rd_data_23(rd_word[207 +: 9]),
        .rd_data_24(rd_word[216 +: 9]),  .rd_data_25(rd_word[225 +: 9]),  .rd_data_26(rd_word[234 +: 9]),
        .rd_data_27(rd_word[243 +: 9]),  .rd_data_28(rd_word[252 +: 9]),  .rd_data_29(rd_word[261 +: 9]),
        .rd_data_30(rd_word[270 +: 9]),  .rd_data_31(rd_word[279 +: 9]),
        .rd_valid(rd_valid), .state(state), .done(done),
        .words_valid(words_valid), .trig_index(trig_index)
    );

    // Model: the full history of words written since the last arm, plus the slot
    // each write landed in (only needed for out-of-range stale reads).
    logic [WW-1:0] wq[$];
    logic [WW-1:0] shadow [DEPTH];
    bit            known [DEPTH];
    int            ncount = 0;
    int            trig_seq = 0;
    bit            trig_pending = 0;
    bit            trig_written = 0;
    int            m_state = 0;
    int            m_post = 0;
    bit            m_rd_valid = 0;
    logic [WW-1:0] m_rd_data = '0;
    bit            m_rd_known = 1;
    bit            model_live = 0;
    int            mw, ma, mp;

    function automatic int m_words();
        return (ncount < DEPTH) ? ncount : DEPTH;
    endfunction

    function automatic int m_trig();
        return trig_seq - (ncount - m_words());
    endfunction

    function automatic logic [WW-1:0] make_word(input int seq, input int salt);
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < 32; k++) begin
            w[k*9 +: 9] = 9'((seq * 13 + k * 5 + salt) % 512);
        end
        return w;
    endfunction

    always @(posedge clk) begin
        model_live = 1;
        if (rst) begin
            m_state      = 0;
            ncount       = 0;
            wq.delete();
            trig_pending = 0;
            trig_written = 0;
            m_post       = 0;
            m_rd_valid   = 0;
            m_rd_data    = '0;
            m_rd_known   = 1;
        end else begin
            if (rd_en && m_state == 3) begin
                mw = m_words();
                ma = int'(rd_addr);
                m_rd_valid = 1;
                if (ma < mw) begin
                    m_rd_data  = wq[ncount - mw + ma];
                    m_rd_known = 1;
                end else begin
                    mp = (ncount >= DEPTH) ? (ncount + ma) % DEPTH : ma;
                    m_rd_data  = shadow[mp];
                    m_rd_known = known[mp];
                end
            end else begin
                m_rd_valid = 0;
            end
            if (arm) begin
                m_state      = 1;
                ncount       = 0;
                wq.delete();
                trig_pending = 0;
                trig_written = 0;
            end else if (m_state == 1 || m_state == 2) begin
                if (m_state == 1 && trigger) begin
                    m_post       = int'(post_count);
                    trig_pending = 1;
                    m_state      = 2;
                end
                if (in_valid) begin
                    wq.push_back(in_word);
                    shadow[ncount % DEPTH] = in_word;
                    known[ncount % DEPTH]  = 1;
                    ncount++;
                    if (trig_pending) begin
                        trig_pending = 0;
                        trig_written = 1;
                        trig_seq     = ncount - 1;
                    end
                    if (trig_written && (ncount - 1 - trig_seq) == m_post) begin
                        m_state = 3;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkWord(input string name, input logic [WW-1:0] actual, input logic [WW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("state", longint'(state), longint'(m_state));
            checkOutput("done", longint'(done), longint'(m_state == 3));
            checkOutput("words_valid", longint'(words_valid), longint'(m_words()));
            checkOutput("rd_valid", longint'(rd_valid), longint'(m_rd_valid));
            if (m_rd_known) begin
                checkWord("rd_data", rd_word, m_rd_data);
            end
            if (m_state == 3) begin
                checkOutput("trig_index", longint'(trig_index), longint'(m_trig()));
            end
        end
    end

    task automatic applyStimulus(input bit a_rst, input bit a_arm, input bit a_trig, input bit a_valid,
                                 input logic [WW-1:0] a_word, input logic [5:0] a_post,
                                 input bit a_rd, input logic [5:0] a_addr);
        @(posedge clk);
        #1;
        rst        = a_rst;
        arm        = a_arm;
        trigger    = a_trig;
        in_valid   = a_valid;
        in_word    = a_word;
        post_count = a_post;
        rd_en      = a_rd;
        rd_addr    = a_addr;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, '0, 6'd0, 0, 6'd0);
    endtask

    task automatic doArm();
        applyStimulus(0, 1, 0, 0, '0, 6'd0, 0, 6'd0);
    endtask

    task automatic writeWord(input int seq, input int salt, input bit trig, input logic [5:0] post);
        applyStimulus(0, 0, trig, 1, make_word(seq, salt), post, 0, 6'd0);
    endtask

    task automatic readAddr(input logic [5:0] a);
        applyStimulus(0, 0, 0, 0, '0, 6'd0, 1, a);
    endtask

    bit            r_rst, r_arm, r_trig, r_valid, r_rd;
    logic [5:0]    r_post, r_addr;
    logic [WW-1:0] r_word;

    initial begin
        $display("[TB] starting des_capture_buffer bench");
        applyStimulus(1, 0, 0, 0, '0, 6'd0, 1, 6'd3);
        applyStimulus(1, 0, 0, 0, '0, 6'd0, 0, 6'd0);
        idle();
        @(negedge clk);
        checkOutput("rst_state", longint'(state), 0);
        checkOutput("rst_words_valid", longint'(words_valid), 0);
        checkOutput("rst_rd_valid", longint'(rd_valid), 0);
        checkOutput("rst_rd_lane0", longint'(rd_word[8:0]), 0);

        // 10 pre-trigger words, trigger word 10, 3 post words.
        doArm();
        for (int i = 0; i < 10; i++) writeWord(i, 0, 0, 6'd0);
        writeWord(10, 0, 1, 6'd3);
        writeWord(11, 0, 0, 6'd0);
        writeWord(12, 0, 0, 6'd0);
        writeWord(13, 0, 0, 6'd0);
        @(negedge clk);
        checkOutput("a_still_post", longint'(state), 2);
        idle();
        @(negedge clk);
        checkOutput("a_state_done", longint'(state), 3);
        checkOutput("a_done", longint'(done), 1);
        checkOutput("a_words_valid", longint'(words_valid), 14);
        checkOutput("a_trig_index", longint'(trig_index), 10);
        checkOutput("a_model_words", longint'(m_words()), 14);
        checkOutput("a_model_trig", longint'(m_trig()), 10);
        for (int i = 0; i < 14; i++) readAddr(6'(i));
        readAddr(6'd5);
        idle();
        @(negedge clk);
        checkOutput("a_rd5_valid", longint'(rd_valid), 1);
        checkOutput("a_rd5_lane0", longint'(rd_word[8:0]), 65);

        // 100 pre-trigger words wrap the 64-entry buffer.
        doArm();
        for (int i = 0; i < 100; i++) writeWord(i, 0, 0, 6'd0);
        writeWord(100, 0, 1, 6'd5);
        for (int i = 101; i < 106; i++) writeWord(i, 0, 0, 6'd0);
        idle();
        @(negedge clk);
        checkOutput("b_words_valid", longint'(words_valid), 64);
        checkOutput("b_trig_index", longint'(trig_index), 58);
        checkOutput("b_model_trig", longint'(m_trig()), 58);
        readAddr(6'd0);
        idle();
        @(negedge clk);
        checkOutput("b_rd0_lane0", longint'(rd_word[8:0]), 34);
        checkOutput("b_rd0_lane31", longint'(rd_word[279 +: 9]), 189);

        // post_count=0 with a word on the trigger cycle; then a stale out-of-range read.
        doArm();
        for (int i = 0; i < 5; i++) writeWord(i, 1, 0, 6'd0);
        writeWord(5, 1, 1, 6'd0);
        idle();
        @(negedge clk);
        checkOutput("c_state_done", longint'(state), 3);
        checkOutput("c_words_valid", longint'(words_valid), 6);
        checkOutput("c_trig_index", longint'(trig_index), 5);
        readAddr(6'd10);
        idle();
        @(negedge clk);
        checkOutput("c_stale_valid", longint'(rd_valid), 1);
        checkOutput("c_stale_lane0", longint'(rd_word[8:0]), 450);

        // arm and trigger together, read in ARMED, trigger without a word, gaps in POST.
        applyStimulus(0, 1, 1, 0, '0, 6'd2, 0, 6'd0);
        idle();
        @(negedge clk);
        checkOutput("d_arm_wins", longint'(state), 1);
        for (int i = 0; i < 4; i++) writeWord(i, 2, 0, 6'd0);
        readAddr(6'd1);
        idle();
        @(negedge clk);
        checkOutput("d_armed_rd_valid", longint'(rd_valid), 0);
        applyStimulus(0, 0, 1, 0, '0, 6'd2, 0, 6'd0);
        idle();
        idle();
        idle();
        @(negedge clk);
        checkOutput("d_gap_post", longint'(state), 2);
        writeWord(4, 2, 0, 6'd0);
        writeWord(5, 2, 0, 6'd0);
        idle();
        @(negedge clk);
        checkOutput("d_post_after_two", longint'(state), 2);
        writeWord(6, 2, 0, 6'd0);
        idle();
        @(negedge clk);
        checkOutput("d_done", longint'(state), 3);
        checkOutput("d_words_valid", longint'(words_valid), 7);
        checkOutput("d_trig_index", longint'(trig_index), 4);

        // Reset in the middle of POST; memory must survive it.
        doArm();
        for (int i = 0; i < 3; i++) writeWord(i, 3, 0, 6'd0);
        writeWord(3, 3, 1, 6'd10);
        writeWord(4, 3, 0, 6'd0);
        writeWord(5, 3, 0, 6'd0);
        applyStimulus(1, 0, 0, 0, '0, 6'd0, 1, 6'd0);
        readAddr(6'd0);
        idle();
        @(negedge clk);
        checkOutput("e_rst_state", longint'(state), 0);
        checkOutput("e_rst_rd_valid", longint'(rd_valid), 0);
        checkOutput("e_rst_words_valid", longint'(words_valid), 0);
        checkOutput("e_rst_trig_index", longint'(trig_index), 0);
        doArm();
        writeWord(9, 4, 1, 6'd0);
        readAddr(6'd2);
        idle();
        @(negedge clk);
        checkOutput("e_mem_kept_lane0", longint'(rd_word[8:0]), 29);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            r_rst   = ($urandom_range(0, 299) == 0);
            if (m_state == 3)      r_arm = ($urandom_range(0, 11) == 0);
            else if (m_state == 0) r_arm = ($urandom_range(0, 2) == 0);
            else                   r_arm = ($urandom_range(0, 149) == 0);
            r_trig  = ($urandom_range(0, 11) == 0);
            r_valid = ($urandom_range(0, 9) < 7);
            r_post  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 8));
            r_rd    = ($urandom_range(0, 1) == 1);
            r_addr  = 6'($urandom_range(0, 63));
            for (int k = 0; k < 32; k++) r_word[k*9 +: 9] = 9'($urandom);
            applyStimulus(r_rst, r_arm, r_trig, r_valid, r_word, r_post, r_rd, r_addr);
        end
        idle();
        idle();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
